// File: rtl/i2c_pkg.sv
// Shared order codes, sequencer states and step kinds
// for the I2C register transaction sequencer.
package i2c_pkg;

    localparam logic [2:0] ORD_START   = 3'd0;
    localparam logic [2:0] ORD_WR      = 3'd1;
    localparam logic [2:0] ORD_RD      = 3'd2;
    localparam logic [2:0] ORD_STOP    = 3'd3;
    localparam logic [2:0] ORD_RESTART = 3'd4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_LO   = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_CLEANUP   = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    typedef enum logic [2:0] {
        K_START,
        K_WR_REG,
        K_WR_DATA,
        K_RESTART,
        K_RD,
        K_STOP
    } step_kind_e;

    // Write: START WR WR STOP; read: START WR RESTART RD STOP
    function automatic step_kind_e step_kind(
        input logic       rw,
        input logic [2:0] idx
    );
        step_kind_e k;
        k = K_STOP;
        case (idx)
            3'd0:    k = K_START;
            3'd1:    k = K_WR_REG;
            3'd2:    k = rw ? K_RESTART : K_WR_DATA;
            3'd3:    k = rw ? K_RD : K_STOP;
            default: k = K_STOP;
        endcase
        return k;
    endfunction

    function automatic logic [2:0] last_step(input logic rw);
        return rw ? 3'd4 : 3'd3;
    endfunction

    function automatic logic [2:0] kind_order(input step_kind_e k);
        logic [2:0] o;
        o = ORD_STOP;
        case (k)
            K_START:   o = ORD_START;
            K_WR_REG:  o = ORD_WR;
            K_WR_DATA: o = ORD_WR;
            K_RESTART: o = ORD_RESTART;
            K_RD:      o = ORD_RD;
            default:   o = ORD_STOP;
        endcase
        return o;
    endfunction

    function automatic logic is_ctl(input step_kind_e k);
        return (k == K_START) || (k == K_RESTART);
    endfunction

endpackage

// File: rtl/i2c_step_timer.sv
// Per-step watchdog: saturating 20-bit counter with
// synchronous clear and an expiry flag at LIMIT.
module i2c_step_timer
    import i2c_pkg::*;
#(
    parameter logic [19:0] LIMIT = 20'd100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [19:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 20'd0;
        end else if (clear) begin
            count <= 20'd0;
        end else if (enable && (count != 20'hFFFFF)) begin
            count <= count + 20'd1;
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Register read/write sequencer driving the i2c_master
// command port with one order per step and a timeout.
module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter logic [15:0] CLK_DIV = 16'd250,
    parameter logic [19:0] TIMEOUT = 20'd100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [6:0]  req_addr,
    input  logic [7:0]  req_reg,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [2:0]  m_order,
    output logic        m_wr_enable,
    output logic [6:0]  m_address,
    output logic [7:0]  m_data,
    output logic [15:0] m_divisor,
    output logic        m_reset,
    input  logic        m_ready,
    input  logic        m_done,
    input  logic        m_finish,
    input  logic [7:0]  m_rdata
);

    logic [2:0] state;
    logic [2:0] step;
    logic       rw_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic [7:0] rd_q;
    logic       err_q;
    logic       done_q;
    logic       done_rise;
    logic       step_ok;
    logic       strobe;
    logic       advance;
    logic       expired;
    step_kind_e kind;

    assign m_divisor = CLK_DIV;
    assign kind      = step_kind(rw_q, step);
    assign done_rise = m_done && !done_q;
    assign strobe    = (state == S_ISSUE) && m_ready;
    assign advance   = (state == S_WAIT_DONE) && step_ok;

    always_comb begin
        step_ok = 1'b0;
        case (kind)
            K_START, K_RESTART:     step_ok = m_ready;
            K_WR_REG, K_WR_DATA:    step_ok = done_rise;
            K_RD:                   step_ok = done_rise;
            default:                step_ok = m_finish;
        endcase
    end

    i2c_step_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state == S_IDLE) || strobe || advance),
        .enable ((state == S_ISSUE) || (state == S_WAIT_LO)
                 || (state == S_WAIT_DONE)),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            step        <= 3'd0;
            rw_q        <= 1'b0;
            reg_q       <= 8'd0;
            wdata_q     <= 8'd0;
            rd_q        <= 8'd0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'd0;
            rsp_err     <= 1'b0;
            busy        <= 1'b0;
            m_order     <= 3'd0;
            m_wr_enable <= 1'b0;
            m_address   <= 7'd0;
            m_data      <= 8'd0;
            m_reset     <= 1'b0;
        end else begin
            done_q      <= m_done;
            m_wr_enable <= 1'b0;
            m_reset     <= 1'b0;
            rsp_valid   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        rw_q      <= req_rw;
                        m_address <= req_addr;
                        reg_q     <= req_reg;
                        wdata_q   <= req_wdata;
                        step      <= 3'd0;
                        rd_q      <= 8'd0;
                        err_q     <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (m_ready) begin
                        m_wr_enable <= 1'b1;
                        m_order     <= kind_order(kind);
                        m_data      <= (kind == K_WR_REG)  ? reg_q :
                                       (kind == K_WR_DATA) ? wdata_q :
                                       8'd0;
                        state       <= is_ctl(kind) ? S_WAIT_LO
                                                    : S_WAIT_DONE;
                    end else if (expired) begin
                        err_q <= 1'b1;
                        state <= S_CLEANUP;
                    end
                end
                S_WAIT_LO: begin
                    if (!m_ready) begin
                        state <= S_WAIT_DONE;
                    end else if (expired) begin
                        err_q <= 1'b1;
                        state <= S_CLEANUP;
                    end
                end
                S_WAIT_DONE: begin
                    // completion is checked first so it beats a timeout
                    if (step_ok) begin
                        if (kind == K_RD) rd_q <= m_rdata;
                        if (step == last_step(rw_q)) begin
                            state <= S_CLEANUP;
                        end else begin
                            step  <= step + 3'd1;
                            state <= S_ISSUE;
                        end
                    end else if (expired) begin
                        err_q <= 1'b1;
                        state <= S_CLEANUP;
                    end
                end
                S_CLEANUP: begin
                    m_reset <= 1'b1;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    rsp_rdata <= (err_q || !rw_q) ? 8'd0 : rd_q;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2c_txn_sequencer.md
# i2c_txn_sequencer

Register-level transaction sequencer in front of the `i2c_master` byte engine. Accepts one register write or register read request at a time. Issues the matching order sequence (START, WR, [RESTART, RD], STOP) on the master's `order`/`wr_enable` command port, tracks completion with `ready`/`done`/`finish`, and returns a one-cycle response with read data or a timeout error. Sits between the host register bank and the master.

## Interface
- `CLK_DIV`, 16'd250: value driven constantly on `m_divisor` (quarter SCL period in clk cycles).
- `TIMEOUT`, 20'd100000: maximum clk cycles allowed per step before abort.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept a request
- `req_rw`  in  1  0 = register write, 1 = register read
- `req_addr`  in  7  slave address
- `req_reg`  in  8  register pointer
- `req_wdata`  in  8  write data
- `rsp_valid`  out  1  one-cycle response pulse
- `rsp_rdata`  out  8  read data; 0 for writes and errors
- `rsp_err`  out  1  step timeout; qualified by `rsp_valid`
- `busy`  out  1  transaction in progress
- `m_order`  out  3  order code to master
- `m_wr_enable`  out  1  one-cycle command strobe
- `m_address`  out  7  slave address to master
- `m_data`  out  8  byte to transmit
- `m_divisor`  out  16  = `CLK_DIV`
- `m_reset`  out  1  one-cycle master re-initialise pulse
- `m_ready`  in  1  master accepting commands
- `m_done`  in  1  byte complete
- `m_finish`  in  1  STOP complete
- `m_rdata`  in  8  received byte

## Operation
- Request latch: on `req_valid && req_ready`, capture `req_*` and clear step index. Select the step list:
  - write: START, WR(`req_reg`), WR(`req_wdata`), STOP
  - read: START, WR(`req_reg`), RESTART, RD, STOP
- FSM states:
  - IDLE: `req_ready=1`. Handshake → ISSUE.
  - ISSUE: wait for `m_ready=1`. Pulse `m_wr_enable` with `m_order`/`m_data` of the current step; timer cleared → WAIT_LO.
  - WAIT_LO: wait for `m_ready=0` → WAIT_DONE. Skipped, i.e. go straight to WAIT_DONE, for WR/RD/STOP.
  - WAIT_DONE: step completes as follows:
    - START/RESTART: `m_ready=1`
    - WR/RD: `m_done` rising
    - STOP: `m_finish=1`
  - On completion in WAIT_DONE:
    - RD: capture `m_rdata`.
    - Last step: → CLEANUP.
    - Otherwise: step+1 → ISSUE.
  - CLEANUP: pulse `m_reset` for one cycle → RESP.
  - RESP: `rsp_valid=1` for one cycle → IDLE.
- Timeout: the step timer counts every cycle in ISSUE, WAIT_LO and WAIT_DONE. Reaching `TIMEOUT` sets an error flag and jumps to CLEANUP, so the response carries `rsp_err=1` and `rsp_rdata=0`.
- `m_address` holds the latched `req_addr` for the whole transaction.
- `busy` = state != IDLE.

## Timing
- Reset values: `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `busy=0`, `m_wr_enable=0`, `m_order=0`, `m_data=0`, `m_address=0`, `m_reset=0`. `m_divisor=CLK_DIV` always. State IDLE, timer 0.
- All outputs registered.
- `m_wr_enable` is exactly one cycle per step and is never asserted while `m_ready=0`.
- `req_ready` drops the cycle after acceptance. It rises the cycle after the `rsp_valid` pulse.
- Minimum gaps:
  - accept → first `m_wr_enable`: 1 cycle
  - `m_finish` → `m_reset`: 1 cycle
  - `m_reset` → `rsp_valid`: 1 cycle
- `m_done` is edge-detected (registered previous value), so a multi-cycle `done` counts once.
- Simultaneous completion and timeout in the same cycle: completion wins.
- `req_valid` while busy is ignored (no queueing).
- `reset` mid-transaction:
  - FSM returns to IDLE next edge with no response.
  - `m_reset` is not pulsed; the system reset resets the master.
- Timer width 20 bits. Saturates, never wraps.

## Structure
- Package `i2c_pkg`:
  - order codes: START=3'd0, WR=3'd1, RD=3'd2, STOP=3'd3, RESTART=3'd4
  - sequencer state encoding
  - step-kind constants
- Sub-module `i2c_step_timer`: clear, enable, saturating 20-bit counter, `expired` output.

## Test plan
- Write 0x50/reg 0x10/data 0xA5 with a master model → orders 0,1,1,3. `m_data` 0x10 then 0xA5. One `m_reset`. `rsp_valid` with `rsp_err=0`, `rsp_rdata=0`.
- Read 0x50/reg 0x20, model returns 0x3C → orders 0,1,4,2,3. `rsp_rdata=0x3C`, `rsp_err=0`.
- Model never pulses `done` on first WR, `TIMEOUT=64` → `rsp_err=1` 64 cycles after the strobe; `m_reset` pulsed; back to IDLE.
- `m_ready` held low 10 cycles before START → strobe delayed until `m_ready=1`. Exactly one strobe.
- Second `req_valid` during a read → ignored. `req_ready=0` throughout; only one response.
- `reset` asserted during WAIT_DONE of RD → next cycle IDLE, `req_ready=1`, no `rsp_valid`.
